ws2812_driver: RTL and testbench

//  Serialises the three 8-bit colour levels from the encoder stage onto one WS2812-style

---
 rtl/rgb_pkg.sv | 23 ++
 rtl/ws2812_driver_if.sv | 26 ++
 rtl/ws2812_bit_timer.sv | 48 ++++
 rtl/ws2812_driver.sv | 153 +++++++++++++++
 tb/tb_ws2812_driver.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_pkg.sv
// Shared colour/pixel types for the WS2812 serialiser: widths, FSM states and
// the GRB packing helper used when a colour is latched.
package rgb_pkg;

    localparam int COLOR_W = 8;
    localparam int PIXEL_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_e;

    // WS2812 parts expect green first, then red, then blue.
    function automatic logic [PIXEL_W-1:0] pack_grb(
        input logic [COLOR_W-1:0] r,
        input logic [COLOR_W-1:0] g,
        input logic [COLOR_W-1:0] b
    );
        return {g, r, b};
    endfunction

endpackage

// File: rtl/ws2812_driver_if.sv
// Colour/handshake/serial-line bundle between the encoder stage and ws2812_driver.
// ready/done handshake: start is accepted on a clk edge only while ready=1; done
// pulses for exactly the one cycle on which ready returns high after a frame.
interface ws2812_driver_if;
    import rgb_pkg::*;

    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic               start;
    logic               ready;
    logic               done;
    logic               led_out;
    state_e             state;

    modport master (
        output red, green, blue, start,
        input  ready, done, led_out, state
    );

    modport slave (
        input  red, green, blue, start,
        output ready, done, led_out, state
    );

endinterface

// File: rtl/ws2812_bit_timer.sv
// One WS2812 bit slot: counts BIT_CYCLES cycles and produces the registered line
// level (high for T1H/T0H cycles depending on bit_val_i). Loaded/stepped by the FSM.
module ws2812_bit_timer #(
    parameter int BIT_CYCLES = 13,
    parameter int T0H_CYCLES = 4,
    parameter int T1H_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic step_i,
    input  logic bit_val_i,
    output logic slot_level_o,
    output logic slot_end_o
);

    localparam int CNT_W = $clog2(BIT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    // level_d is the level of the cycle that cnt_d will index, so the line is a flop output.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (load_i) begin
            cnt_d   = '0;
            level_d = 1'b1;
        end else if (step_i) begin
            cnt_d   = cnt_q + 1'b1;
            level_d = int'(cnt_d) < (bit_val_i ? T1H_CYCLES : T0H_CYCLES);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign slot_level_o = level_q;
    assign slot_end_o   = (cnt_q == CNT_W'(BIT_CYCLES - 1));

endmodule

// File: rtl/ws2812_driver.sv
// WS2812 single-wire serialiser: latches one GRB colour, sends it NUM_LEDS times, then
// holds the latch gap. Define WS2812_AUTO_REFRESH_EN to restart a frame whenever idle.
module ws2812_driver
    import rgb_pkg::*;
#(
    parameter int NUM_LEDS     = 1,
    parameter int BIT_CYCLES   = 13,
    parameter int T0H_CYCLES   = 4,
    parameter int T1H_CYCLES   = 8,
    parameter int RESET_CYCLES = 800
) (
    input  logic           clk,
    input  logic           reset,
    ws2812_driver_if.slave bus
);

    localparam int BIT_W = $clog2(PIXEL_W);
    localparam int LED_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int GAP_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES)) begin : g_bad_timing
        $error("ws2812_driver: timing must satisfy 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
    end
    if (NUM_LEDS < 1 || RESET_CYCLES < 1) begin : g_bad_size
        $error("ws2812_driver: NUM_LEDS and RESET_CYCLES must be at least 1");
    end

    state_e             state_q;
    logic [PIXEL_W-1:0] shift_q;
    logic [PIXEL_W-1:0] latch_q;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic [LED_W-1:0]   led_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic               ready_q;
    logic               done_q;

    logic [PIXEL_W-1:0] pix_in;
    logic               start_eff;
    logic               accept;
    logic               last_bit;
    logic               last_led;
    logic               timer_load;
    logic               timer_step;
    logic               timer_bit;
    logic               slot_level;
    logic               slot_end;

`ifdef WS2812_AUTO_REFRESH_EN
    assign start_eff = bus.start | 1'b1;
`else
    assign start_eff = bus.start;
`endif

    assign pix_in   = pack_grb(bus.red, bus.green, bus.blue);
    assign accept   = (state_q == IDLE) && start_eff && ready_q;
    assign last_bit = (bit_cnt_q == BIT_W'(PIXEL_W - 1));
    assign last_led = (led_cnt_q == LED_W'(NUM_LEDS - 1));

    // The timer is reloaded with the bit that will occupy the next slot, so the line
    // rises on the very first cycle of each slot with no bubble between slots.
    always_comb begin
        timer_load = 1'b0;
        timer_step = 1'b0;
        timer_bit  = 1'b0;
        if (accept) begin
            timer_load = 1'b1;
            timer_bit  = pix_in[PIXEL_W-1];
        end else if (state_q == SEND) begin
            if (!slot_end) begin
                timer_step = 1'b1;
                timer_bit  = shift_q[PIXEL_W-1];
            end else if (!last_bit) begin
                timer_load = 1'b1;
                timer_bit  = shift_q[PIXEL_W-2];
            end else if (!last_led) begin
                timer_load = 1'b1;
                timer_bit  = latch_q[PIXEL_W-1];
            end
        end
    end

    ws2812_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES),
        .T0H_CYCLES (T0H_CYCLES),
        .T1H_CYCLES (T1H_CYCLES)
    ) u_bit_timer (
        .clk          (clk),
        .reset        (reset),
        .load_i       (timer_load),
        .step_i       (timer_step),
        .bit_val_i    (timer_bit),
        .slot_level_o (slot_level),
        .slot_end_o   (slot_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            latch_q   <= '0;
            bit_cnt_q <= '0;
            led_cnt_q <= '0;
            gap_cnt_q <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        latch_q   <= pix_in;
                        shift_q   <= pix_in;
                        bit_cnt_q <= '0;
                        led_cnt_q <= '0;
                        ready_q   <= 1'b0;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    if (slot_end) begin
                        if (!last_bit) begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            shift_q   <= shift_q << 1;
                        end else if (!last_led) begin
                            led_cnt_q <= led_cnt_q + 1'b1;
                            bit_cnt_q <= '0;
                            shift_q   <= latch_q;
                        end else begin
                            gap_cnt_q <= '0;
                            state_q   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_W'(RESET_CYCLES - 1)) begin
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready   = ready_q;
    assign bus.done    = done_q;
    assign bus.led_out = slot_level;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_ws2812_driver.sv
// Bench for ws2812_driver (1-LED and 3-LED instances); per-cycle {led_out,ready,done}
// is compared against a waveform built from the bit-timing rules of the line protocol.
module tb_ws2812_driver;
    import rgb_pkg::*;

    localparam int BITC = 13;
    localparam int T0H  = 4;
    localparam int T1H  = 8;
    localparam int RST  = 800;

    logic clk;
    logic reset;

    ws2812_driver_if bus1 ();
    ws2812_driver_if bus3 ();

    ws2812_driver #(.NUM_LEDS(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    ws2812_driver #(.NUM_LEDS(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    logic [2:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         ev_cyc   = -1;
    int         ev_kind  = 0;
    logic [7:0] ev_blue  = 8'h00;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] sample(input int n);
        if (n == 1) return {bus1.led_out, bus1.ready, bus1.done};
        return {bus3.led_out, bus3.ready, bus3.done};
    endfunction

    // driver tasks
    task automatic set_rgb(input int n, input logic [23:0] grb);
        if (n == 1) begin
            bus1.green = grb[23:16]; bus1.red = grb[15:8]; bus1.blue = grb[7:0];
        end else begin
            bus3.green = grb[23:16]; bus3.red = grb[15:8]; bus3.blue = grb[7:0];
        end
    endtask

    task automatic set_start(input int n, input logic v);
        if (n == 1) bus1.start = v;
        else        bus3.start = v;
    endtask

    // reference model: one frame is every bit slot of every LED, then the gap, then done
    task automatic push_frame(input int n, input logic [23:0] grb);
        for (int l = 0; l < n; l++)
            for (int b = 23; b >= 0; b--)
                for (int c = 0; c < BITC; c++)
                    exp_q.push_back({(c < (grb[b] ? T1H : T0H)), 2'b00});
        repeat (RST) exp_q.push_back(3'b000);
        exp_q.push_back(3'b011);
    endtask

    task automatic start_frame(input int n, input logic [23:0] grb);
        logic [2:0] s;
        @(negedge clk);
        set_rgb(n, grb);
        set_start(n, 1'b1);
        s = sample(n);
        check_eq("ready_before_accept", 32'(s[1]), 32'd1);
        @(posedge clk);
        #1 set_start(n, 1'b0);
    endtask

    // mode 0: quiet inputs, 1: random start/colour noise, 2: scheduled event at ev_cyc
    task automatic check_frame(input int n, input int mode, input string tag);
        int         k = 0;
        logic [2:0] e;
        logic [2:0] s;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            k++;
            e = exp_q.pop_front();
            s = sample(n);
            check_eq($sformatf("%s cyc%0d", tag, k), 32'(s), 32'(e));
            if (mode == 1) begin
                if (exp_q.size() > 0) begin
                    set_start(n, 1'($urandom_range(0, 1)));
                    set_rgb(n, (k == 5) ? 24'h00ff00 : 24'($urandom));
                end else begin
                    set_start(n, 1'b0);
                end
            end else if (mode == 2 && k == ev_cyc) begin
                if (ev_kind == 0) bus1.blue = ev_blue;
                else              set_start(n, 1'b0);
            end
        end
    endtask

    task automatic check_idle(input int n, input string tag);
        logic [2:0] s;
        @(negedge clk);
        s = sample(n);
        check_eq(tag, 32'(s), 32'b010);
    endtask

    // stimulus
    initial begin
        logic [2:0]  s;
        logic [23:0] pix;
        reset = 1'b0;
        bus1.start = 1'b0; bus3.start = 1'b0;
        set_rgb(1, 24'h0); set_rgb(3, 24'h0);

        // 1: asynchronous reset before any clock edge
        #2 reset = 1'b1;
        #1;
        s = sample(1);
        check_eq("reset_dut1", 32'(s), 32'b010);
        s = sample(3);
        check_eq("reset_dut3", 32'(s), 32'b010);
        check_eq("reset_state", 32'(bus1.state), 32'(IDLE));

`ifdef WS2812_AUTO_REFRESH_EN
        // 6: free-running refresh, blue changed mid-frame lands in the next frame only
        pix = 24'h80_00_01;
        set_rgb(1, pix);
        ev_blue = 8'h3c;
        ev_cyc  = 500;
        ev_kind = 0;
        push_frame(1, pix);
        push_frame(1, {pix[23:8], ev_blue});
        @(negedge clk);
        reset = 1'b0;
        check_frame(1, 2, "auto_refresh");
`else
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_idle(1, "idle_after_reset");

        // 2: G7 and B0 set, everything else 0
        push_frame(1, 24'h80_00_01);
        start_frame(1, 24'h80_00_01);
        check_frame(1, 0, "basic");
        check_idle(1, "basic_idle");

        // 3: start pulses and colour changes during the frame are ignored
        push_frame(1, 24'h80_00_01);
        start_frame(1, 24'h80_00_01);
        check_frame(1, 1, "noisy");
        check_idle(1, "noisy_idle");

        // 4: reset inside bit 10, then a clean frame
        pix = 24'h5a3c96;
        push_frame(1, pix);
        start_frame(1, pix);
        for (int k = 1; k <= 10 * BITC; k++) begin
            @(negedge clk);
            check_eq($sformatf("pre_reset cyc%0d", k), 32'(sample(1)), 32'(exp_q.pop_front()));
        end
        exp_q.delete();
        @(posedge clk);
        #1 s = sample(1);
        check_eq("bit10_first_cycle_high", 32'(s[2]), 32'd1);
        #1 reset = 1'b1;
        #1 s = sample(1);
        check_eq("mid_frame_reset", 32'(s), 32'b010);
        check_eq("mid_frame_reset_state", 32'(bus1.state), 32'(IDLE));
        @(negedge clk);
        reset = 1'b0;
        pix = 24'($urandom);
        push_frame(1, pix);
        start_frame(1, pix);
        check_frame(1, 0, "after_reset");

        // 5: three LEDs, red=AA
        push_frame(3, 24'h00_aa_00);
        start_frame(3, 24'h00_aa_00);
        check_frame(3, 0, "chain3");
        check_idle(3, "chain3_idle");

        // random colours on both chain lengths
        for (int i = 0; i < 3; i++) begin
            pix = 24'($urandom);
            push_frame(1, pix);
            start_frame(1, pix);
            check_frame(1, (i == 1) ? 1 : 0, $sformatf("rand1_%0d", i));
            check_idle(1, "rand1_idle");
        end
        pix = 24'($urandom);
        push_frame(3, pix);
        start_frame(3, pix);
        check_frame(3, 1, "rand3");
        check_idle(3, "rand3_idle");

        // start held high: the next frame follows the done cycle directly
        pix = 24'($urandom);
        push_frame(1, pix);
        push_frame(1, pix);
        start_frame(1, pix);
        set_start(1, 1'b1);
        ev_kind = 1;
        ev_cyc  = 24 * BITC + RST + 1 + 20;
        check_frame(1, 2, "held_start");
        check_idle(1, "held_start_idle");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
